// File: rtl/wr_ddr_data_pkg.sv
// Shared DDR app-interface constants and write-initiator state encoding.
// WR_DDR_BYTE_MASK_EN widens FIFO entries to carry a per-word byte mask.
package wr_ddr_data_pkg;

   localparam logic [2:0] DDR_CMD_WR    = 3'b000;
   localparam logic [2:0] DDR_CMD_RD    = 3'b001;
   localparam int         DDR_DATA_W    = 512;
   localparam int         DDR_MASK_W    = 64;
   localparam int         DDR_ADDR_W    = 30;
   localparam int         DDR_BURST_LEN = 8;
   localparam int         WR_CNT_W      = 7;

`ifdef WR_DDR_BYTE_MASK_EN
   localparam int WR_FIFO_W = DDR_DATA_W + DDR_MASK_W;
`else
   localparam int WR_FIFO_W = DDR_DATA_W;
`endif

   typedef enum logic [1:0] {
      WR_IDLE  = 2'd0,
      WR_WRITE = 2'd1,
      WR_DONE  = 2'd2
   } wr_state_e;

   // Burst address with natural wrap at the DDR address width.
   function automatic logic [DDR_ADDR_W-1:0] burstAddr(
      input logic [DDR_ADDR_W-1:0] base,
      input logic [WR_CNT_W-1:0]   idx,
      input logic [DDR_ADDR_W-1:0] stride
   );
      logic [DDR_ADDR_W-1:0] idxWide;
      idxWide = {{(DDR_ADDR_W-WR_CNT_W){1'b0}}, idx};
      return base + stride * idxWide;
   endfunction

endpackage

// File: rtl/wr_ddr_data_fifo.sv
// Small synchronous FIFO with registered full/empty flags; head is the
// oldest entry and is valid whenever empty_o is low.
module wr_ddr_fifo #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic             full_q, empty_q;
   logic             doPush, doPop;

   assign doPush = push_i && !full_q;
   assign doPop  = pop_i && !empty_q;

   always_comb begin
      count_d = count_q;
      if (doPush && !doPop) begin
         count_d = count_q + (PTR_W+1)'(1);
      end else if (doPop && !doPush) begin
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   // Flags are registered from the next occupancy so they never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
         if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
         count_q <= count_d;
         full_q  <= (count_d == DEPTH_C);
         empty_q <= (count_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= data_i;
   end

   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign head_o  = mem_q[rdPtr_q];

endmodule

// File: rtl/wr_ddr_data.sv
// DDR write initiator: buffers producer words and issues one wdf beat plus one
// write command per word. Optional WR_DDR_BYTE_MASK_EN adds wr_data_mask.
module wr_ddr_data
   import wr_ddr_data_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int ADDR_STRIDE = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_start,
   input  logic [DDR_ADDR_W-1:0] wr_addr,
   input  logic [WR_CNT_W-1:0]   wr_burst_num,
   input  logic                  wr_data_valid,
   input  logic [DDR_DATA_W-1:0] wr_data,
`ifdef WR_DDR_BYTE_MASK_EN
   input  logic [DDR_MASK_W-1:0] wr_data_mask,
`endif
   output logic                  wr_data_rdy,
   output logic                  wr_done,
   output logic                  wr_busy,
   input  logic                  ddr_rdy,
   input  logic                  ddr_wdf_rdy,
   output logic                  ddr_en,
   output logic [2:0]            ddr_cmd,
   output logic [DDR_ADDR_W-1:0] ddr_addr,
   output logic [DDR_DATA_W-1:0] ddr_wdf_data,
   output logic                  ddr_wdf_wren,
   output logic                  ddr_wdf_end,
   output logic [DDR_MASK_W-1:0] ddr_wdf_mask
);

   localparam logic [DDR_ADDR_W-1:0] STRIDE_C = DDR_ADDR_W'(ADDR_STRIDE);

   wr_state_e             state_q, state_d;
   logic [DDR_ADDR_W-1:0] base_q, base_d;
   logic [WR_CNT_W-1:0]   num_q, num_d;
   logic [WR_CNT_W-1:0]   inCnt_q, inCnt_d;
   logic [WR_CNT_W-1:0]   datCnt_q, datCnt_d;
   logic [WR_CNT_W-1:0]   cmdCnt_q, cmdCnt_d;

   logic                  writing;
   logic                  fifoFull, fifoEmpty;
   logic                  wordAcc, beatAcc, cmdAcc;
   logic [WR_FIFO_W-1:0]  fifoIn, fifoHead;
   logic [DDR_DATA_W-1:0] headData;
   logic [DDR_MASK_W-1:0] headMask;

   assign writing = (state_q == WR_WRITE);

   // Ready uses the registered full flag, so a same-cycle pop frees space only next cycle.
   assign wr_data_rdy  = writing && !fifoFull && (inCnt_q < num_q);
   assign ddr_wdf_wren = writing && !fifoEmpty && (datCnt_q < num_q);
   assign ddr_wdf_end  = ddr_wdf_wren;
   assign ddr_en       = writing && (cmdCnt_q < datCnt_q);
   assign ddr_cmd      = DDR_CMD_WR;
   assign wr_busy      = (state_q != WR_IDLE);

   assign wordAcc = wr_data_valid && wr_data_rdy;
   assign beatAcc = ddr_wdf_wren && ddr_wdf_rdy;
   assign cmdAcc  = ddr_en && ddr_rdy;

   assign ddr_addr     = ddr_en ? burstAddr(base_q, cmdCnt_q, STRIDE_C) : '0;
   assign ddr_wdf_data = ddr_wdf_wren ? headData : '0;

`ifdef WR_DDR_BYTE_MASK_EN
   assign fifoIn       = {wr_data_mask, wr_data};
   assign headData     = fifoHead[DDR_DATA_W-1:0];
   assign headMask     = fifoHead[WR_FIFO_W-1:DDR_DATA_W];
   assign ddr_wdf_mask = ddr_wdf_wren ? headMask : '0;
`else
   assign fifoIn       = wr_data;
   assign headData     = fifoHead;
   assign headMask     = '0;
   assign ddr_wdf_mask = headMask;
`endif

   wr_ddr_fifo #(
      .WIDTH (WR_FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (wordAcc),
      .data_i  (fifoIn),
      .pop_i   (beatAcc),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .head_o  (fifoHead)
   );

   // Job sequencing: the job ends only once every command has been accepted.
   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      num_d    = num_q;
      inCnt_d  = inCnt_q;
      datCnt_d = datCnt_q;
      cmdCnt_d = cmdCnt_q;
      wr_done  = 1'b0;
      unique case (state_q)
         WR_IDLE: begin
            if (wr_start) begin
               base_d   = wr_addr;
               num_d    = wr_burst_num;
               inCnt_d  = '0;
               datCnt_d = '0;
               cmdCnt_d = '0;
               state_d  = (wr_burst_num == '0) ? WR_DONE : WR_WRITE;
            end
         end
         WR_WRITE: begin
            if (wordAcc) inCnt_d  = inCnt_q + WR_CNT_W'(1);
            if (beatAcc) datCnt_d = datCnt_q + WR_CNT_W'(1);
            if (cmdAcc)  cmdCnt_d = cmdCnt_q + WR_CNT_W'(1);
            if (cmdCnt_q == num_q) state_d = WR_DONE;
         end
         WR_DONE: begin
            wr_done = 1'b1;
            state_d = WR_IDLE;
         end
         default: state_d = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= WR_IDLE;
         base_q   <= '0;
         num_q    <= '0;
         inCnt_q  <= '0;
         datCnt_q <= '0;
         cmdCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         num_q    <= num_d;
         inCnt_q  <= inCnt_d;
         datCnt_q <= datCnt_d;
         cmdCnt_q <= cmdCnt_d;
      end
   end

endmodule

// File: tb/tb_wr_ddr_data.sv
// Self-checking bench for wr_ddr_data against a counting reference model
// of words in, beats out and commands issued; honours WR_DDR_BYTE_MASK_EN.
module tb_wr_ddr_data;

   localparam int DEPTH  = 4;
   localparam int STRIDE = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         wr_start = 1'b0;
   logic [29:0]  wr_addr = '0;
   logic [6:0]   wr_burst_num = '0;
   logic         wr_data_valid = 1'b0;
   logic [511:0] wr_data = '0;
   logic [63:0]  wr_data_mask = '0;
   logic         wr_data_rdy, wr_done, wr_busy;
   logic         ddr_rdy = 1'b0, ddr_wdf_rdy = 1'b0;
   logic         ddr_en, ddr_wdf_wren, ddr_wdf_end;
   logic [2:0]   ddr_cmd;
   logic [29:0]  ddr_addr;
   logic [511:0] ddr_wdf_data;
   logic [63:0]  ddr_wdf_mask;

   int checks = 0;
   int errors = 0;

   wr_ddr_data #(.FIFO_DEPTH(DEPTH), .ADDR_STRIDE(STRIDE)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_start      (wr_start),
      .wr_addr       (wr_addr),
      .wr_burst_num  (wr_burst_num),
      .wr_data_valid (wr_data_valid),
      .wr_data       (wr_data),
`ifdef WR_DDR_BYTE_MASK_EN
      .wr_data_mask  (wr_data_mask),
`endif
      .wr_data_rdy   (wr_data_rdy),
      .wr_done       (wr_done),
      .wr_busy       (wr_busy),
      .ddr_rdy       (ddr_rdy),
      .ddr_wdf_rdy   (ddr_wdf_rdy),
      .ddr_en        (ddr_en),
      .ddr_cmd       (ddr_cmd),
      .ddr_addr      (ddr_addr),
      .ddr_wdf_data  (ddr_wdf_data),
      .ddr_wdf_wren  (ddr_wdf_wren),
      .ddr_wdf_end   (ddr_wdf_end),
      .ddr_wdf_mask  (ddr_wdf_mask)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " rdy"},   wr_data_rdy,  '0);
      checkOutput({tag, " done"},  wr_done,      '0);
      checkOutput({tag, " busy"},  wr_busy,      '0);
      checkOutput({tag, " en"},    ddr_en,       '0);
      checkOutput({tag, " cmd"},   ddr_cmd,      '0);
      checkOutput({tag, " addr"},  ddr_addr,     '0);
      checkOutput({tag, " data"},  ddr_wdf_data, '0);
      checkOutput({tag, " wren"},  ddr_wdf_wren, '0);
      checkOutput({tag, " end"},   ddr_wdf_end,  '0);
      checkOutput({tag, " mask"},  ddr_wdf_mask, '0);
   endtask

   // Modes: 0 all ready, 1 wdf_rdy low on cycles 2..10, 2 ddr_rdy toggling, 3 random.
   task automatic applyStimulus(input logic [29:0] base, input int num, input int mode,
                                input int abortAfter, input bit midStart);
      logic [511:0] words[$];
      logic [63:0]  masks[$];
      logic [511:0] w;
      logic [63:0]  expMask;
      int  wordsIn = 0, beats = 0, cmds = 0, doneIn = 0;
      bit  finished = 1'b0;
      bit  expRdy, expWren, expEn;
      for (int i = 0; i < num; i++) begin
         for (int j = 0; j < 16; j++) w[j*32 +: 32] = $urandom;
         words.push_back(w);
         masks.push_back((i == 0) ? 64'hFF00_0000_0000_0000 : {$urandom, $urandom});
      end
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         @(posedge clk); #1;
         wr_start      = (cyc == 0) || (midStart && cyc == 3);
         wr_addr       = (cyc == 0) ? base : 30'h2AB_CDE0;
         wr_burst_num  = (cyc == 0) ? 7'(num) : 7'd5;
         wr_data_valid = (mode == 3) ? ($urandom_range(3) != 0) : 1'b1;
         wr_data       = (wordsIn < num) ? words[wordsIn] : {16{$urandom}};
         wr_data_mask  = (wordsIn < num) ? masks[wordsIn] : 64'hDEAD_BEEF_0000_FFFF;
         ddr_wdf_rdy   = (mode == 1) ? !(cyc >= 2 && cyc <= 10) :
                         (mode == 3) ? 1'($urandom_range(1)) : 1'b1;
         ddr_rdy       = (mode == 2) ? (cyc % 2 == 0) :
                         (mode == 3) ? 1'($urandom_range(1)) : 1'b1;
         @(negedge clk);
         if (cyc == 0) begin
            checkOutput("idle busy before start", wr_busy, 1'b0);
            if (num == 0) doneIn = 1;
            continue;
         end
         if (abortAfter > 0 && cmds == abortAfter) begin
            rst_n = 1'b0;
            #1;
            checkAllZero("abort");
            wr_start      = 1'b0;
            wr_data_valid = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
         end
         expWren = (wordsIn > beats);
         expEn   = (cmds < beats);
         expRdy  = ((wordsIn - beats) < DEPTH) && (wordsIn < num);
         checkOutput("wr_done",      wr_done,      doneIn == 1);
         checkOutput("wr_busy",      wr_busy,      1'b1);
         checkOutput("wr_data_rdy",  wr_data_rdy,  expRdy);
         checkOutput("ddr_wdf_wren", ddr_wdf_wren, expWren);
         checkOutput("ddr_wdf_end",  ddr_wdf_end,  expWren);
         checkOutput("ddr_en",       ddr_en,       expEn);
         if (expWren) begin
            checkOutput("ddr_wdf_data", ddr_wdf_data, words[beats]);
`ifdef WR_DDR_BYTE_MASK_EN
            expMask = masks[beats];
`else
            expMask = '0;
`endif
            checkOutput("ddr_wdf_mask", ddr_wdf_mask, expMask);
         end
         checkOutput("ddr_addr", ddr_addr, expEn ? 30'(base + 30'(STRIDE * cmds)) : 30'h0);
         if (doneIn == 1) finished = 1'b1;
         if (doneIn > 0) doneIn--;
         if (wr_data_valid && expRdy) wordsIn++;
         if (expWren && ddr_wdf_rdy) beats++;
         if (expEn && ddr_rdy) begin
            cmds++;
            if (cmds == num) doneIn = 2;
         end
      end
      checkOutput("job timeout", finished, 1'b1);
      @(posedge clk); #1;
      wr_start = 1'b0;
      @(negedge clk);
      checkOutput("busy after done", wr_busy, 1'b0);
      checkOutput("done after done", wr_done, 1'b0);
   endtask

   initial begin
      logic [29:0] rb;
      $display("[TB] start");
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkAllZero("reset");
      rst_n = 1'b1;

      applyStimulus(30'h100, 4, 0, 0, 1'b0);
      applyStimulus(30'h040, 0, 0, 0, 1'b0);
      applyStimulus(30'h400, 8, 1, 0, 1'b0);
      applyStimulus(30'h800, 3, 2, 0, 1'b0);
      applyStimulus(30'hC00, 6, 0, 2, 1'b0);
      applyStimulus(30'h200, 1, 0, 0, 1'b0);
      applyStimulus(30'h300, 5, 0, 0, 1'b1);
      applyStimulus(30'h3FFF_FFF0, 6, 3, 0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         rb = 30'($urandom);
         applyStimulus(rb, $urandom_range(20, 1), 3, 0, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
